// File: rtl/mem_arbiter.sv
// Round-robin arbiter/sequencer between the CPU (port A) and loader (port B)
// for the shared 4096x16 memory with one-cycle registered read latency.
module mem_arbiter #(
  parameter int AW = 12,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          reset_n,
  // Request handshake: req is held with we/addr/wdata stable until a one-cycle
  // ack; the requester drops req at the edge ending the ack cycle, otherwise
  // the request is arbitrated again. Read results arrive with a rvalid pulse.
  input  logic          req_a,
  input  logic          we_a,
  input  logic [AW-1:0] addr_a,
  input  logic [DW-1:0] wdata_a,
  input  logic          req_b,
  input  logic          we_b,
  input  logic [AW-1:0] addr_b,
  input  logic [DW-1:0] wdata_b,
  output logic          ack_a,
  output logic          ack_b,
  output logic          rvalid_a,
  output logic          rvalid_b,
  output logic [DW-1:0] rdata_a,
  output logic [DW-1:0] rdata_b,
  output logic          busy,
  output logic [1:0]    state_dbg,   // 0 = IDLE, 1 = ISSUE, 2 = DATA
  output logic [AW-1:0] mem_adress,
  output logic          mem_read,
  output logic          mem_write,
  output logic [DW-1:0] mem_indata,
  input  logic [DW-1:0] mem_outdata
);

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, DATA = 2'd2} state_t;

  state_t        state_q, state_d;
  logic          last_b_q, last_b_d;   // last granted port; owner of the current transaction
  logic          ack_a_q, ack_a_d, ack_b_q, ack_b_d;
  logic          rvalid_a_q, rvalid_a_d, rvalid_b_q, rvalid_b_d;
  logic          busy_q, busy_d;
  logic          mem_read_q, mem_read_d, mem_write_q, mem_write_d;
  logic [AW-1:0] mem_adress_q, mem_adress_d;
  logic [DW-1:0] mem_indata_q, mem_indata_d;
  logic [DW-1:0] rdata_a_q, rdata_a_d, rdata_b_q, rdata_b_d;
  logic          grant_b;
  logic          grant_we;

  always_comb begin
    state_d      = state_q;
    last_b_d     = last_b_q;
    ack_a_d      = 1'b0;
    ack_b_d      = 1'b0;
    rvalid_a_d   = 1'b0;
    rvalid_b_d   = 1'b0;
    busy_d       = 1'b0;
    mem_read_d   = 1'b0;
    mem_write_d  = 1'b0;
    mem_adress_d = mem_adress_q;
    mem_indata_d = mem_indata_q;
    rdata_a_d    = rdata_a_q;
    rdata_b_d    = rdata_b_q;
    grant_b      = req_b && (!req_a || !last_b_q);
    grant_we     = grant_b ? we_b : we_a;
    case (state_q)
      IDLE: begin
        if (req_a || req_b) begin
          last_b_d     = grant_b;
          ack_a_d      = !grant_b;
          ack_b_d      = grant_b;
          mem_adress_d = grant_b ? addr_b : addr_a;
          mem_indata_d = grant_b ? wdata_b : wdata_a;
          mem_write_d  = grant_we;
          mem_read_d   = !grant_we;
          busy_d       = 1'b1;
          state_d      = ISSUE;
        end
      end
      ISSUE: begin
        // A write is finished once the memory has sampled the strobe.
        state_d = mem_write_q ? IDLE : DATA;
        busy_d  = !mem_write_q;
      end
      DATA: begin
        if (last_b_q) begin
          rdata_b_d  = mem_outdata;
          rvalid_b_d = 1'b1;
        end else begin
          rdata_a_d  = mem_outdata;
          rvalid_a_d = 1'b1;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      last_b_q     <= 1'b1;
      ack_a_q      <= 1'b0;
      ack_b_q      <= 1'b0;
      rvalid_a_q   <= 1'b0;
      rvalid_b_q   <= 1'b0;
      busy_q       <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_adress_q <= '0;
      mem_indata_q <= '0;
      rdata_a_q    <= '0;
      rdata_b_q    <= '0;
    end else begin
      state_q      <= state_d;
      last_b_q     <= last_b_d;
      ack_a_q      <= ack_a_d;
      ack_b_q      <= ack_b_d;
      rvalid_a_q   <= rvalid_a_d;
      rvalid_b_q   <= rvalid_b_d;
      busy_q       <= busy_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      mem_adress_q <= mem_adress_d;
      mem_indata_q <= mem_indata_d;
      rdata_a_q    <= rdata_a_d;
      rdata_b_q    <= rdata_b_d;
    end
  end

  assign ack_a      = ack_a_q;
  assign ack_b      = ack_b_q;
  assign rvalid_a   = rvalid_a_q;
  assign rvalid_b   = rvalid_b_q;
  assign rdata_a    = rdata_a_q;
  assign rdata_b    = rdata_b_q;
  assign busy       = busy_q;
  assign state_dbg  = state_q;
  assign mem_adress = mem_adress_q;
  assign mem_read   = mem_read_q;
  assign mem_write  = mem_write_q;
  assign mem_indata = mem_indata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: vector table, hand-written timing sequences and a
// randomized run against a cycle-count/shadow-memory reference model.
module tb_mem_arbiter;

  localparam int AW = 12;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          req_a, we_a, req_b, we_b;
  logic [AW-1:0] addr_a, addr_b;
  logic [DW-1:0] wdata_a, wdata_b;
  logic          ack_a, ack_b, rvalid_a, rvalid_b, busy;
  logic [DW-1:0] rdata_a, rdata_b;
  logic [1:0]    state_dbg;
  logic [AW-1:0] mem_adress;
  logic          mem_read, mem_write;
  logic [DW-1:0] mem_indata, mem_outdata;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic mem_clr = 1'b0;
  logic [DW-1:0] mem [4096];
  logic [DW-1:0] shadow [4096];

  typedef struct {
    logic          port;   // 0 = A, 1 = B
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] exp_rdata;
  } vec_t;
  vec_t vecs[8];

  mem_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_a(req_a), .we_a(we_a), .addr_a(addr_a), .wdata_a(wdata_a),
    .req_b(req_b), .we_b(we_b), .addr_b(addr_b), .wdata_b(wdata_b),
    .ack_a(ack_a), .ack_b(ack_b), .rvalid_a(rvalid_a), .rvalid_b(rvalid_b),
    .rdata_a(rdata_a), .rdata_b(rdata_b), .busy(busy), .state_dbg(state_dbg),
    .mem_adress(mem_adress), .mem_read(mem_read), .mem_write(mem_write),
    .mem_indata(mem_indata), .mem_outdata(mem_outdata)
  );

  // Clock and memory model (registered read, one-cycle latency)
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 16; i++) mem[12'h200 + 12'(i)] <= '0;
    end else if (mem_write) begin
      mem[mem_adress] <= mem_indata;
    end
    if (mem_read) mem_outdata <= mem[mem_adress];
  end

  initial begin
    #300000;
    $display("FAIL watchdog time limit reached checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    req_a = 1'b0;
    req_b = 1'b0;
    step();
    step();
    reset_n = 1'b1;
    cyc = 0;
  endtask

  task automatic set_req(input logic p, input logic r, input logic w,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (p) begin
      req_b = r; we_b = w; addr_b = a; wdata_b = d;
    end else begin
      req_a = r; we_a = w; addr_a = a; wdata_a = d;
    end
  endtask

  // One isolated transaction from an idle arbiter, with full timing checks.
  task automatic do_txn(input string nm, input logic p, input logic w,
                        input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic [DW-1:0] e, output int ack_at);
    int n;
    logic [DW-1:0] other;
    other = p ? rdata_a : rdata_b;
    set_req(p, 1'b1, w, a, d);
    n = 0;
    do begin
      step();
      n++;
    end while (!(p ? ack_b : ack_a) && n < 8);
    ack_at = cyc;
    chk({nm, "_ack_latency"}, n, 1);
    chk({nm, "_other_ack"}, p ? ack_a : ack_b, 0);
    chk({nm, "_mem_write"}, mem_write, w);
    chk({nm, "_mem_read"}, mem_read, !w);
    chk({nm, "_mem_adress"}, mem_adress, a);
    if (w) chk({nm, "_mem_indata"}, mem_indata, d);
    if (p) req_b = 1'b0; else req_a = 1'b0;
    step();
    chk({nm, "_strobe_drop"}, {mem_read, mem_write}, 0);
    if (!w) begin
      chk({nm, "_busy_data"}, busy, 1);
      step();
      chk({nm, "_rvalid"}, p ? rvalid_b : rvalid_a, 1);
      chk({nm, "_rdata"}, p ? rdata_b : rdata_a, e);
      step();
      chk({nm, "_rvalid_pulse"}, p ? rvalid_b : rvalid_a, 0);
      chk({nm, "_rdata_hold"}, p ? rdata_b : rdata_a, e);
    end else begin
      chk({nm, "_busy_after_write"}, busy, 0);
    end
    chk({nm, "_other_rdata"}, p ? rdata_a : rdata_b, other);
  endtask

  // Randomized traffic against a reference model: the arbiter is idle from
  // cycle idle_from on; a read occupies 3 cycles, a write 2; ties go to the
  // port not granted last; reads return the shadow memory content.
  task automatic run_random(input int ncyc);
    logic [DW-1:0] exp_q_a[$];
    logic [DW-1:0] exp_q_b[$];
    int idle_from, due_a, due_b;
    logic last_b, sa, sb, swa, swb, g_b, w, ea, eb;
    logic [AW-1:0] saa, sab, a;
    logic [DW-1:0] sda, sdb, d, cur_a, cur_b;
    for (int i = 0; i < 16; i++) shadow[12'h200 + 12'(i)] = '0;
    mem_clr = 1'b1;
    do_reset();
    mem_clr = 1'b0;
    idle_from = 0; due_a = -1; due_b = -1;
    last_b = 1'b1; cur_a = '0; cur_b = '0;
    for (int c = 1; c <= ncyc; c++) begin
      if (req_a && ack_a) req_a = 1'b0;
      else if (!req_a && $urandom_range(0, 2) == 0)
        set_req(1'b0, 1'b1, 1'($urandom_range(0, 1)), 12'h200 + 12'($urandom_range(0, 15)), 16'($urandom));
      if (req_b && ack_b) req_b = 1'b0;
      else if (!req_b && $urandom_range(0, 2) == 0)
        set_req(1'b1, 1'b1, 1'($urandom_range(0, 1)), 12'h200 + 12'($urandom_range(0, 15)), 16'($urandom));
      sa = req_a; swa = we_a; saa = addr_a; sda = wdata_a;
      sb = req_b; swb = we_b; sab = addr_b; sdb = wdata_b;
      step();
      ea = 1'b0;
      eb = 1'b0;
      if (c - 1 >= idle_from && (sa || sb)) begin
        g_b = sb && (!sa || !last_b);
        w = g_b ? swb : swa;
        a = g_b ? sab : saa;
        d = g_b ? sdb : sda;
        if (g_b) eb = 1'b1; else ea = 1'b1;
        last_b = g_b;
        idle_from = c + (w ? 1 : 2);
        chk("rnd_mem_adress", mem_adress, a);
        chk("rnd_mem_write", mem_write, w);
        chk("rnd_mem_read", mem_read, !w);
        if (w) begin
          chk("rnd_mem_indata", mem_indata, d);
          shadow[a] = d;
        end else if (g_b) begin
          exp_q_b.push_back(shadow[a]);
          due_b = c + 2;
        end else begin
          exp_q_a.push_back(shadow[a]);
          due_a = c + 2;
        end
      end else begin
        chk("rnd_strobes_idle", {mem_read, mem_write}, 0);
      end
      chk("rnd_ack_a", ack_a, ea);
      chk("rnd_ack_b", ack_b, eb);
      chk("rnd_busy", busy, c < idle_from);
      chk("rnd_rvalid_a", rvalid_a, c == due_a);
      chk("rnd_rvalid_b", rvalid_b, c == due_b);
      if (c == due_a) begin
        if (exp_q_a.size() == 0) chk("rnd_exp_q_a_empty", 1, 0);
        else cur_a = exp_q_a.pop_front();
      end
      if (c == due_b) begin
        if (exp_q_b.size() == 0) chk("rnd_exp_q_b_empty", 1, 0);
        else cur_b = exp_q_b.pop_front();
      end
      chk("rnd_rdata_a", rdata_a, cur_a);
      chk("rnd_rdata_b", rdata_b, cur_b);
    end
    chk("rnd_exp_q_a_left", exp_q_a.size(), 0);
    chk("rnd_exp_q_b_left", exp_q_b.size(), 0);
  endtask

  initial begin
    int ack_at, ack_prev, nack, n;
    logic grants[$];
    vecs[0] = '{1'b0, 1'b1, 12'h123, 16'hBEEF, 16'h0000};
    vecs[1] = '{1'b0, 1'b0, 12'h123, 16'h0000, 16'hBEEF};
    vecs[2] = '{1'b1, 1'b1, 12'h7FF, 16'h0001, 16'h0000};
    vecs[3] = '{1'b1, 1'b1, 12'h000, 16'hFFFF, 16'h0000};
    vecs[4] = '{1'b1, 1'b0, 12'h7FF, 16'h0000, 16'h0001};
    vecs[5] = '{1'b0, 1'b0, 12'h000, 16'h0000, 16'hFFFF};
    vecs[6] = '{1'b1, 1'b1, 12'h555, 16'h1234, 16'h0000};
    vecs[7] = '{1'b0, 1'b0, 12'h555, 16'h0000, 16'h1234};
    we_a = 1'b0; we_b = 1'b0; addr_a = '0; addr_b = '0; wdata_a = '0; wdata_b = '0;
    req_a = 1'b0; req_b = 1'b0; reset_n = 1'b0;

    // Reset values, then a quiet idle period
    do_reset();
    chk("rst_ack", {ack_a, ack_b}, 0);
    chk("rst_rvalid", {rvalid_a, rvalid_b}, 0);
    chk("rst_busy", busy, 0);
    chk("rst_state", state_dbg, 0);
    chk("rst_strobes", {mem_read, mem_write}, 0);
    chk("rst_mem_adress", mem_adress, 0);
    chk("rst_mem_indata", mem_indata, 0);
    chk("rst_rdata_a", rdata_a, 0);
    chk("rst_rdata_b", rdata_b, 0);
    for (int i = 0; i < 10; i++) begin
      step();
      chk("idle_strobes", {mem_read, mem_write}, 0);
      chk("idle_busy", busy, 0);
    end

    // Vector table: isolated transactions, including back-to-back B writes
    ack_prev = 0;
    for (int i = 0; i < 8; i++) begin
      do_txn($sformatf("vec%0d", i), vecs[i].port, vecs[i].we, vecs[i].addr,
             vecs[i].wdata, vecs[i].exp_rdata, ack_at);
      if (i == 3) chk("b2b_write_ack_gap", ack_at - ack_prev, 2);
      ack_prev = ack_at;
    end

    // Simultaneous reads after reset: A wins the first tie
    do_txn("pre_a", 1'b0, 1'b1, 12'h010, 16'h1111, 16'h0, ack_at);
    do_txn("pre_b", 1'b1, 1'b1, 12'h020, 16'h2222, 16'h0, ack_at);
    do_reset();
    set_req(1'b0, 1'b1, 1'b0, 12'h010, 16'h0);
    set_req(1'b1, 1'b1, 1'b0, 12'h020, 16'h0);
    for (int c = 1; c <= 7; c++) begin
      step();
      chk($sformatf("sim_ack_a_c%0d", c), ack_a, c == 1);
      chk($sformatf("sim_ack_b_c%0d", c), ack_b, c == 4);
      chk($sformatf("sim_rvalid_a_c%0d", c), rvalid_a, c == 3);
      chk($sformatf("sim_rvalid_b_c%0d", c), rvalid_b, c == 6);
      if (ack_a) req_a = 1'b0;
      if (ack_b) req_b = 1'b0;
    end
    chk("sim_rdata_a", rdata_a, 16'h1111);
    chk("sim_rdata_b", rdata_b, 16'h2222);

    // Sustained contention: both re-raise right after each ack
    set_req(1'b0, 1'b1, 1'($urandom_range(0, 1)), 12'h010, 16'($urandom));
    set_req(1'b1, 1'b1, 1'($urandom_range(0, 1)), 12'h020, 16'($urandom));
    nack = 0;
    n = 0;
    while (nack < 8 && n < 60) begin
      step();
      n++;
      chk("cont_strobe_excl", mem_read && mem_write, 0);
      if (ack_a) begin
        grants.push_back(1'b0); nack++; req_a = 1'b0;
      end else if (!req_a) begin
        set_req(1'b0, 1'b1, 1'($urandom_range(0, 1)), 12'h010, 16'($urandom));
      end
      if (ack_b) begin
        grants.push_back(1'b1); nack++; req_b = 1'b0;
      end else if (!req_b) begin
        set_req(1'b1, 1'b1, 1'($urandom_range(0, 1)), 12'h020, 16'($urandom));
      end
    end
    req_a = 1'b0;
    req_b = 1'b0;
    chk("cont_grant_count", grants.size(), 8);
    for (int k = 0; k < grants.size(); k++)
      chk($sformatf("cont_grant%0d", k), grants[k], k % 2);
    for (int i = 0; i < 5; i++) step();

    // Reset during ISSUE of an A read aborts it
    set_req(1'b0, 1'b1, 1'b0, 12'h123, 16'h0);
    step();
    chk("abort_ack_a", ack_a, 1);
    reset_n = 1'b0;
    req_a = 1'b0;
    step();
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("abort_rvalid_a", rvalid_a, 0);
      chk("abort_rdata_a", rdata_a, 0);
      chk("abort_busy", busy, 0);
      chk("abort_state", state_dbg, 0);
    end
    do_txn("after_abort", 1'b0, 1'b0, 12'h123, 16'h0, 16'hBEEF, ack_at);

    run_random(400);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter and sequencer for the shared 4096x16 main memory. It accepts access requests from two requesters, the CPU (port A) and the loader/IO engine (port B), and grants them round-robin. It drives the memory's registered address, read, write and write-data inputs, and returns read data to the owning port once the memory's one-cycle registered read latency has elapsed. It sits between the requesters and the memory block; no other block drives the memory control lines.

## Interface
- AW, 12, address width (memory depth 2^AW words)
- DW, 16, data width
- clk  in  1  system clock, all logic on posedge
- reset_n  in  1  reset, synchronous, active-low
- req_a / req_b  in  1  access request, held until ack
- we_a / we_b  in  1  1 = write, 0 = read; stable while req high
- addr_a / addr_b  in  AW  word address; stable while req high
- wdata_a / wdata_b  in  DW  write data; stable while req high
- ack_a / ack_b  out  1  one-cycle pulse: request accepted and issued to memory
- rvalid_a / rvalid_b  out  1  one-cycle pulse: rdata of that port updated
- rdata_a / rdata_b  out  DW  last read data for that port, held until the port's next read completes
- busy  out  1  high when FSM is not in IDLE
- mem_adress  out  AW  memory address (registered)
- mem_read / mem_write  out  1  memory strobes (registered, never both 1)
- mem_indata  out  DW  memory write data (registered)
- mem_outdata  in  DW  memory read data, valid the cycle after mem_read is sampled

## Operation
- FSM states are IDLE, ISSUE and DATA. Arbitration happens only in IDLE.
- IDLE:
  - No request: stay in IDLE. mem_read = mem_write = 0.
  - Exactly one req high: grant that port.
  - Both req high: grant the port not granted last (last_grant register). After reset last_grant = B, so A wins the first tie.
  - On grant: register mem_adress, mem_indata, mem_read = ~we, mem_write = we; update last_grant; go to ISSUE.
- ISSUE:
  - Strobes are presented to the memory for exactly this cycle; ack of the granted port = 1.
  - Write: go to IDLE, strobes cleared.
  - Read: go to DATA, strobes cleared.
- DATA:
  - mem_outdata is valid. At the end of the cycle, capture it into rdata of the granted port, set rvalid of that port for the next cycle, go to IDLE.
- req/we/addr/wdata are sampled only at the IDLE edge.
  - A requester must drop req at the edge that ends its ack cycle; otherwise the request is treated as new and is arbitrated again.
  - req raised during ISSUE or DATA waits for the next IDLE.
- mem_indata is don't-care for reads but is still loaded from the granted port. mem_adress keeps its last value while idle.
- Outputs of the non-granted port stay 0 (ack, rvalid), and its rdata is unchanged.

## Timing
- Reset (reset_n = 0 at a posedge):
  - State goes to IDLE; last_grant = B.
  - ack_*, rvalid_*, busy, mem_read and mem_write = 0.
  - mem_adress, mem_indata and rdata_* = 0.
- Reset mid-transaction aborts the transaction: no ack or rvalid is produced afterwards. A write already sampled by the memory may have completed.
- Cycle 0 (IDLE) samples the request. Cycle 1 is ISSUE (ack high, strobe high). The memory acts at the end of cycle 1.
- Read:
  - Cycle 2 is DATA.
  - Cycle 3: rvalid high, rdata valid, FSM back in IDLE and arbitrating.
  - Occupancy is 3 cycles; the next grant is issued at the end of cycle 3.
- Write: occupancy is 2 cycles. Cycle 2 is IDLE and can grant the next request.
- Worst-case wait for a port with req held under contention: one foreign transaction (at most 3 cycles) plus its own.
- busy = 1 exactly in ISSUE and DATA.

## Test plan
- Reset, then idle:
  - Drive reset_n = 0 for 2 cycles, then 1.
  - Required: all outputs at their reset values; mem_read and mem_write stay 0 for 10 idle cycles.
- Single write then read on A:
  - Write addr_a = 0x123, wdata_a = 0xBEEF; ack_a one cycle later, mem_write for exactly 1 cycle.
  - Then read addr_a = 0x123: rvalid_a in cycle 3, rdata_a = 0xBEEF held afterwards.
- Simultaneous requests after reset:
  - A reads 0x010 and B reads 0x020, both held.
  - Required: A granted first (ack_a), then B (ack_b in cycle 4); rvalid_b in cycle 6 with the B data; rdata_a unchanged by B's read.
- Sustained contention:
  - req_a and req_b re-raised immediately after each ack for 8 transactions.
  - Required: grants strictly alternate A, B, A, B…; mem_read and mem_write are never 1 together.
- Back-to-back writes:
  - B writes 0x7FF = 0x0001, then 0x000 = 0xFFFF, each at the earliest legal cycle.
  - Required: acks 2 cycles apart; a subsequent read from 0x7FF returns 0x0001 and from 0x000 returns 0xFFFF.
- Reset mid-read:
  - Assert reset_n = 0 during ISSUE of an A read.
  - Required: no rvalid_a; rdata_a = 0; FSM in IDLE; a next request is served normally.
